// File: rtl/ysyx_2022040010_exe_mem_buf.sv
// EX->MEM pipeline buffer: 2-entry skid (head H + skid S) carrying the ALU result and sideband fields.
// Latency: 1 cycle from accept to mem_* when EMPTY or when ONE pops in the same cycle; 1 entry/cycle throughput.
// Backpressure: ex_ready is a pure register (low only in TWO); mem_ready only reaches state/data flops.
//
// Ports: clk/rst_n (async active-low); ex_* = EX-side instruction under ex_valid/ex_alu_over/ex_ready;
//        mem_* = head entry under mem_valid/mem_ready; flush kills everything; fwd_* = per-entry
//        forwarding view {skid, head}; stall_cnt = saturating count of mem_valid & ~mem_ready cycles.
// Optional feature macro: YSYX_2022040010_EXM_FWD_EN (undefined -> fwd_* tied to 0).
module ysyx_2022040010_exe_mem_buf #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                ex_alu_over,
    output logic                ex_ready,
    input  logic [DATA_W-1:0]   ex_alu_result,
    input  logic [PC_W-1:0]     ex_pc,
    input  logic [4:0]          ex_rd,
    input  logic                ex_rd_wen,
    input  logic                ex_mem_ren,
    input  logic                ex_mem_wen,
    input  logic [2:0]          ex_mem_size,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic                flush,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [DATA_W-1:0]   mem_alu_result,
    output logic [PC_W-1:0]     mem_pc,
    output logic [4:0]          mem_rd,
    output logic                mem_rd_wen,
    output logic                mem_mem_ren,
    output logic                mem_mem_wen,
    output logic [2:0]          mem_mem_size,
    output logic [DATA_W-1:0]   mem_store_data,
    output logic [1:0]          fwd_valid,
    output logic [9:0]          fwd_rd,
    output logic [2*DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [PC_W-1:0]   pc;
        logic [4:0]        rd;
        logic              rd_wen;
        logic              mem_ren;
        logic              mem_wen;
        logic [2:0]        mem_size;
        logic [DATA_W-1:0] store_data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ex_ready;
    entry_t           r_head;
    entry_t           r_skid;
    entry_t           w_in;
    logic             w_accept;
    logic             w_pop;
    logic             w_ld_head_in;
    logic             w_ld_skid_in;
    logic             w_ld_head_skid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in = '{alu_result: ex_alu_result, pc: ex_pc, rd: ex_rd, rd_wen: ex_rd_wen,
                    mem_ren: ex_mem_ren, mem_wen: ex_mem_wen, mem_size: ex_mem_size,
                    store_data: ex_store_data};

    assign mem_valid = (r_state != ST_EMPTY);
    assign ex_ready  = r_ex_ready;
    // An instruction is only taken once the ALU has finished; flush discards the incoming one.
    assign w_accept  = ex_valid & ex_alu_over & r_ex_ready & ~flush;
    assign w_pop     = mem_valid & mem_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_head_in   = 1'b0;
        w_ld_skid_in   = 1'b0;
        w_ld_head_skid = 1'b0;
        if (flush) begin
            // A pop in this cycle still completed on the MEM side; nothing else survives.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_ld_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt  = ST_TWO;
                        w_ld_skid_in = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_ex_ready <= 1'b1;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Ready is derived from the next state so it never depends combinationally on mem_ready.
            r_ex_ready <= (w_state_nxt != ST_TWO);
            if (w_ld_head_in) begin
                r_head <= w_in;
            end else if (w_ld_head_skid) begin
                r_head <= r_skid;
            end
            if (w_ld_skid_in) begin
                r_skid <= w_in;
            end
        end
    end

    // Saturating stall counter; deliberately survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (mem_valid && !mem_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt      = r_stall_cnt;
    assign mem_alu_result = r_head.alu_result;
    assign mem_pc         = r_head.pc;
    assign mem_rd         = r_head.rd;
    assign mem_rd_wen     = r_head.rd_wen;
    assign mem_mem_ren    = r_head.mem_ren;
    assign mem_mem_wen    = r_head.mem_wen;
    assign mem_mem_size   = r_head.mem_size;
    assign mem_store_data = r_head.store_data;

`ifdef YSYX_2022040010_EXM_FWD_EN
    // Loads cannot forward yet (data not loaded); x0 is never a real destination.
    assign fwd_valid[0] = (r_state != ST_EMPTY) & r_head.rd_wen & ~r_head.mem_ren & (r_head.rd != 5'd0);
    assign fwd_valid[1] = (r_state == ST_TWO)   & r_skid.rd_wen & ~r_skid.mem_ren & (r_skid.rd != 5'd0);
    assign fwd_rd       = {r_skid.rd, r_head.rd};
    assign fwd_data     = {r_skid.alu_result, r_head.alu_result};
`else
    assign fwd_valid = '0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_exe_mem_buf.sv
// Bench for the EX->MEM skid buffer: table-driven streaming/backpressure/gating/flush vectors,
// then hand sequences for forwarding and asynchronous reset in the TWO state.
// Inputs change 1 time unit after the rising edge; outputs are compared at that same point.
module tb_ysyx_2022040010_exe_mem_buf;

    localparam int DATA_W = 64;
    localparam int PC_W   = 64;
    localparam int CNT_W  = 32;

    logic                clk;
    logic                rst_n;
    logic                ex_valid;
    logic                ex_alu_over;
    logic                ex_ready;
    logic [DATA_W-1:0]   ex_alu_result;
    logic [PC_W-1:0]     ex_pc;
    logic [4:0]          ex_rd;
    logic                ex_rd_wen;
    logic                ex_mem_ren;
    logic                ex_mem_wen;
    logic [2:0]          ex_mem_size;
    logic [DATA_W-1:0]   ex_store_data;
    logic                flush;
    logic                mem_valid;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_alu_result;
    logic [PC_W-1:0]     mem_pc;
    logic [4:0]          mem_rd;
    logic                mem_rd_wen;
    logic                mem_mem_ren;
    logic                mem_mem_wen;
    logic [2:0]          mem_mem_size;
    logic [DATA_W-1:0]   mem_store_data;
    logic [1:0]          fwd_valid;
    logic [9:0]          fwd_rd;
    logic [2*DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]    stall_cnt;

    int n_checks;
    int n_fail;

    ysyx_2022040010_exe_mem_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_over(ex_alu_over), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen), .ex_mem_size(ex_mem_size),
        .ex_store_data(ex_store_data), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_result(mem_alu_result), .mem_pc(mem_pc), .mem_rd(mem_rd),
        .mem_rd_wen(mem_rd_wen), .mem_mem_ren(mem_mem_ren), .mem_mem_wen(mem_mem_wen),
        .mem_mem_size(mem_mem_size), .mem_store_data(mem_store_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PC and store data are derived from the result so the sideband path is also checked.
    task automatic drive(input logic v, input logic over, input logic mr, input logic fl,
                         input logic [63:0] res, input logic [4:0] rd, input logic wen,
                         input logic ren);
        ex_valid      = v;
        ex_alu_over   = over;
        mem_ready     = mr;
        flush         = fl;
        ex_alu_result = res;
        ex_pc         = res ^ 64'h8000_1000;
        ex_store_data = res + 64'd1;
        ex_rd         = rd;
        ex_rd_wen     = wen;
        ex_mem_ren    = ren;
        ex_mem_wen    = ~ren & ~wen;
        ex_mem_size   = 3'd3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic        over;
        logic        mr;
        logic        fl;
        logic [63:0] res;
        logic        exp_mv;
        logic        exp_rdy;
        logic        chk_res;
        logic [63:0] exp_res;
        int          exp_stall;
    } vec_t;

    vec_t vecs [18];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //           v  ov mr fl res        mv rdy chk exp_res  stall
        // streaming
        vecs[0]  = '{1, 1, 1, 0, 64'h10,    1, 1, 1, 64'h10,    0};
        vecs[1]  = '{1, 1, 1, 0, 64'h20,    1, 1, 1, 64'h20,    0};
        vecs[2]  = '{1, 1, 1, 0, 64'h30,    1, 1, 1, 64'h30,    0};
        vecs[3]  = '{0, 0, 1, 0, 64'h0,     0, 1, 0, 64'h0,     0};
        // backpressure: A then B fill the buffer, C is refused, then in-order drain
        vecs[4]  = '{1, 1, 0, 0, 64'hA,     1, 1, 1, 64'hA,     0};
        vecs[5]  = '{1, 1, 0, 0, 64'hB,     1, 0, 1, 64'hA,     1};
        vecs[6]  = '{1, 1, 0, 0, 64'hC,     1, 0, 1, 64'hA,     2};
        vecs[7]  = '{0, 0, 1, 0, 64'h0,     1, 1, 1, 64'hB,     2};
        vecs[8]  = '{0, 0, 1, 0, 64'h0,     0, 1, 0, 64'h0,     2};
        // alu_over gating
        vecs[9]  = '{1, 0, 1, 0, 64'h77,    0, 1, 0, 64'h0,     2};
        vecs[10] = '{1, 0, 1, 0, 64'h77,    0, 1, 0, 64'h0,     2};
        vecs[11] = '{1, 0, 1, 0, 64'h77,    0, 1, 0, 64'h0,     2};
        vecs[12] = '{1, 1, 0, 0, 64'h55,    1, 1, 1, 64'h55,    2};
        vecs[13] = '{0, 0, 1, 0, 64'h0,     0, 1, 0, 64'h0,     2};
        // flush in TWO with a new instruction present; counter is not cleared
        vecs[14] = '{1, 1, 0, 0, 64'h1,     1, 1, 1, 64'h1,     2};
        vecs[15] = '{1, 1, 0, 0, 64'h2,     1, 0, 1, 64'h1,     3};
        vecs[16] = '{1, 1, 0, 1, 64'h3,     0, 1, 0, 64'h0,     4};
        vecs[17] = '{0, 0, 0, 0, 64'h0,     0, 1, 0, 64'h0,     4};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 64'h0, 5'd0, 0, 0);
        #12;
        check("reset_mem_valid", {127'd0, mem_valid}, 128'd0);
        check("reset_ex_ready",  {127'd0, ex_ready},  128'd1);
        check("reset_fwd_valid", {126'd0, fwd_valid}, 128'd0);
        check("reset_stall_cnt", {96'd0, stall_cnt},  128'd0);
        check("reset_head_data", {64'd0, mem_alu_result}, 128'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].over, vecs[i].mr, vecs[i].fl, vecs[i].res, 5'd1, 1'b1, 1'b0);
            step();
            check($sformatf("v%0d_mem_valid", i), {127'd0, mem_valid}, {127'd0, vecs[i].exp_mv});
            check($sformatf("v%0d_ex_ready", i),  {127'd0, ex_ready},  {127'd0, vecs[i].exp_rdy});
            check($sformatf("v%0d_stall_cnt", i), {96'd0, stall_cnt},  {96'd0, 32'(vecs[i].exp_stall)});
            if (vecs[i].chk_res) begin
                check($sformatf("v%0d_result", i), {64'd0, mem_alu_result}, {64'd0, vecs[i].exp_res});
                check($sformatf("v%0d_pc", i), {64'd0, mem_pc}, {64'd0, vecs[i].exp_res ^ 64'h8000_1000});
                check($sformatf("v%0d_store", i), {64'd0, mem_store_data}, {64'd0, vecs[i].exp_res + 64'd1});
            end
        end

        // Forwarding: load (rd=5) in head, ALU op (rd=7, 0x99) in skid.
        drive(1, 1, 0, 0, 64'h11, 5'd5, 1, 1);
        step();
        check("fwd_head_rd",  {123'd0, mem_rd}, 128'd5);
        check("fwd_head_ren", {127'd0, mem_mem_ren}, 128'd1);
        drive(1, 1, 0, 0, 64'h99, 5'd7, 1, 0);
        step();
        check("fwd_two_stall", {96'd0, stall_cnt}, 128'd5);
`ifdef YSYX_2022040010_EXM_FWD_EN
        check("fwd_valid_ld_alu", {126'd0, fwd_valid}, 128'd2);
        check("fwd_rd_pair",      {118'd0, fwd_rd}, {118'd0, 5'd7, 5'd5});
        check("fwd_data_skid",    fwd_data, {64'h99, 64'h11});
`else
        check("fwd_valid_off", {126'd0, fwd_valid}, 128'd0);
        check("fwd_rd_off",    {118'd0, fwd_rd}, 128'd0);
        check("fwd_data_off",  fwd_data, 128'd0);
`endif
        drive(0, 0, 0, 1, 64'h0, 5'd0, 0, 0);
        step();
        check("fwd_after_flush", {126'd0, fwd_valid}, 128'd0);
        check("flush_stall_kept", {96'd0, stall_cnt}, 128'd6);
        // rd = 0 in head never forwards; rd = 3 in skid does.
        drive(1, 1, 0, 0, 64'h42, 5'd0, 1, 0);
        step();
        check("rd0_result", {64'd0, mem_alu_result}, 128'h42);
        check("rd0_fwd_valid", {126'd0, fwd_valid}, 128'd0);
        drive(1, 1, 0, 0, 64'h43, 5'd3, 1, 0);
        step();
`ifdef YSYX_2022040010_EXM_FWD_EN
        check("rd0_skid_fwd", {126'd0, fwd_valid}, 128'd2);
`else
        check("rd0_skid_fwd", {126'd0, fwd_valid}, 128'd0);
`endif
        check("two_ready_low", {127'd0, ex_ready}, 128'd0);
        check("two_stall", {96'd0, stall_cnt}, 128'd7);

        // Asynchronous reset in TWO, between clock edges.
        drive(0, 0, 0, 0, 64'h0, 5'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", {127'd0, mem_valid}, 128'd0);
        check("arst_stall_cnt", {96'd0, stall_cnt},  128'd0);
        check("arst_ex_ready",  {127'd0, ex_ready},  128'd1);
        check("arst_fwd_valid", {126'd0, fwd_valid}, 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        drive(1, 1, 1, 0, 64'h5A, 5'd2, 1, 0);
        step();
        check("post_arst_valid",  {127'd0, mem_valid}, 128'd1);
        check("post_arst_result", {64'd0, mem_alu_result}, 128'h5A);
        check("post_arst_stall",  {96'd0, stall_cnt}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
